apb_arbiter_master: RTL

- Two-requester APB master that shares one APB bus among the CPU data port (requester 0) and a secondary master such as the UART/debug loader (requester 1).
- Arbitrates round-robin, then sequences the APB SETUP/ACCESS phases.
- Decodes the target slave from the address into one-hot PSEL and muxes PRDATA/PREADY back.
- Sits between the RV32I core's bus interface and the peripheral slaves (GPIO, UART, register slaves).

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_rr_arbiter.sv | 40 ++++
 rtl/apb_arbiter_master.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the two-requester APB master.
//   apb_state_e  : transfer sequencer states (IDLE, SETUP, ACCESS, DONE)
//   DECERR_DATA  : rdata returned when the address decodes to no slave
//   TIMEOUT_DATA : rdata returned when an ACCESS phase times out
// -----------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_state_e;

   localparam logic [31:0] DECERR_DATA  = 32'h0000_0000;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
// Two-way round-robin arbiter. The grant is combinational from the request
// levels; the priority pointer moves to the other requester whenever a
// transfer completes.
// Ports:
//   i_pclk, i_preset_n : clock, asynchronous active-low reset
//   i_req[1:0]         : request levels
//   i_advance          : one-cycle pulse when the granted transfer finishes
//   i_done_id          : requester that just finished
//   o_gnt_valid        : at least one request is pending
//   o_gnt_id           : winning requester (0 or 1)
// -----------------------------------------------------------------------------
module apb_rr_arbiter (
   input  logic       i_pclk,
   input  logic       i_preset_n,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   input  logic       i_done_id,
   output logic       o_gnt_valid,
   output logic       o_gnt_id
);

   // Requester that wins a tie.
   logic r_ptr;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of process evaluation order.
   always_ff @(posedge i_pclk or negedge i_preset_n) begin
      if (!i_preset_n)
         r_ptr <= 1'b0;
      else if (i_advance)
         r_ptr <= ~i_done_id;
   end

   assign o_gnt_valid = |i_req;
   // Tie goes to the pointer; a lone request wins outright.
   assign o_gnt_id    = (&i_req) ? r_ptr : i_req[1];

endmodule

// File: rtl/apb_arbiter_master.sv
// -----------------------------------------------------------------------------
// apb_arbiter_master
// Shares one APB bus between two requesters (0: CPU data port, 1: secondary
// master). Arbitrates round-robin, decodes the slave index from
// addr[SEL_LSB +: 4] into one-hot PSEL, runs SETUP/ACCESS and returns the
// selected slave's PRDATA/PREADY to the winner with a one-cycle done strobe.
//
// Ports:
//   PCLK, PRESET            : clock, asynchronous active-low reset
//   req/we [1:0]            : per-requester request level and write enable
//   addr0/1, wdata0/1       : per-requester address and write data
//   rdata, done[1:0], err   : completion data, one-hot strobe, error flag
//   PSEL, PADDR, PWRITE,
//   PENABLE, PWDATA         : APB master outputs
//   PRDATA_ALL, PREADY_ALL  : concatenated slave responses (slave i at 32i)
//
// Build option: define APB_TIMEOUT_EN to bound the ACCESS phase to
// TIMEOUT_CYC cycles; on expiry the transfer ends with err=1 and
// rdata=TIMEOUT_DATA. Without it ACCESS waits indefinitely.
// -----------------------------------------------------------------------------
module apb_arbiter_master
   import apb_pkg::*;
#(
   parameter int NUM_SLV     = 4,
   parameter int ADDR_W      = 12,
   parameter int SEL_LSB     = 12,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                   PCLK,
   input  logic                   PRESET,
   input  logic [1:0]             req,
   input  logic [1:0]             we,
   input  logic [31:0]            addr0,
   input  logic [31:0]            addr1,
   input  logic [31:0]            wdata0,
   input  logic [31:0]            wdata1,
   output logic [31:0]            rdata,
   output logic [1:0]             done,
   output logic                   err,
   output logic [NUM_SLV-1:0]     PSEL,
   output logic [ADDR_W-1:0]      PADDR,
   output logic                   PWRITE,
   output logic                   PENABLE,
   output logic [31:0]            PWDATA,
   input  logic [32*NUM_SLV-1:0]  PRDATA_ALL,
   input  logic [NUM_SLV-1:0]     PREADY_ALL
);

   apb_state_e          r_state, w_state_nxt;
   logic                r_gnt_id;
   logic [3:0]          r_idx;
   logic                r_pwrite;
   logic [ADDR_W-1:0]   r_paddr;
   logic [31:0]         r_pwdata;
   logic [31:0]         r_rdata;
   logic                r_err;

   logic                w_gnt_valid, w_gnt_id, w_take;
   logic                w_win_we;
   logic [31:0]         w_win_addr, w_win_wdata;
   logic [3:0]          w_win_idx;
   logic                w_dec_err;
   logic [31:0]         w_prdata;
   logic                w_pready;
   logic                w_timeout;
   logic                w_unused;

   apb_rr_arbiter u_arb (
      .i_pclk      (PCLK),
      .i_preset_n  (PRESET),
      .i_req       (req),
      .i_advance   (r_state == DONE),
      .i_done_id   (r_gnt_id),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_id    (w_gnt_id)
   );

   // Requests are only looked at in IDLE; in flight, req changes are ignored.
   assign w_take      = (r_state == IDLE) && w_gnt_valid;
   assign w_win_we    = w_gnt_id ? we[1]  : we[0];
   assign w_win_addr  = w_gnt_id ? addr1  : addr0;
   assign w_win_wdata = w_gnt_id ? wdata1 : wdata0;
   assign w_win_idx   = w_win_addr[SEL_LSB +: 4];
   assign w_dec_err   = {28'd0, w_win_idx} >= 32'(NUM_SLV);
   // Upper address bits outside PADDR and the index field carry no meaning.
   assign w_unused    = ^w_win_addr;

   // Response mux: only the selected slave's PREADY/PRDATA are visible.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      w_prdata = '0;
      w_pready = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (r_idx == 4'(i)) begin
            w_prdata = PRDATA_ALL[32*i +: 32];
            w_pready = PREADY_ALL[i];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   logic [TMO_W-1:0] r_tmo_cnt;

   // Counts completed ACCESS cycles of the current transfer.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET)
         r_tmo_cnt <= '0;
      else if (r_state == SETUP)
         r_tmo_cnt <= '0;
      else if (r_state == ACCESS)
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end

   assign w_timeout = (r_state == ACCESS) && !w_pready && (r_tmo_cnt == TMO_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_take) w_state_nxt = w_dec_err ? DONE : SETUP;
         SETUP:   w_state_nxt = ACCESS;
         ACCESS:  if (w_pready || w_timeout) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Transfer latch and completion data.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         r_gnt_id <= 1'b0;
         r_idx    <= '0;
         r_pwrite <= 1'b0;
         r_paddr  <= '0;
         r_pwdata <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else if (w_take) begin
         r_gnt_id <= w_gnt_id;
         r_idx    <= w_win_idx;
         r_pwrite <= w_win_we;
         r_paddr  <= w_win_addr[ADDR_W-1:0];
         r_pwdata <= w_win_wdata;
         r_err    <= w_dec_err;
         if (w_dec_err)
            r_rdata <= DECERR_DATA;
      end else if (r_state == ACCESS) begin
         if (w_pready) begin
            if (!r_pwrite)
               r_rdata <= w_prdata;
         end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= TIMEOUT_DATA;
         end
      end
   end

   always_comb begin
      PSEL = '0;
      for (int i = 0; i < NUM_SLV; i++)
         PSEL[i] = ((r_state == SETUP) || (r_state == ACCESS)) && (r_idx == 4'(i));
   end

   assign PENABLE = (r_state == ACCESS);
   assign PADDR   = r_paddr;
   assign PWRITE  = r_pwrite;
   assign PWDATA  = r_pwdata;
   assign rdata   = r_rdata;
   assign done    = (r_state != DONE) ? 2'b00 : (r_gnt_id ? 2'b10 : 2'b01);
   assign err     = (r_state == DONE) && r_err;

endmodule
